// File: rtl/pifo_shift.sv
// Shift-register PIFO: entries kept sorted by priority (FIFO among ties), head always at slot 0.
// Latency: push/pop visible at head next cycle. Backpressure: ready low when full unless EVICT_ON_FULL.
module pifo_shift #(
    parameter int NUM_ELEMENTS  = 16,
    parameter int MAX_PRIORITY  = 256,
    parameter int DATA_WIDTH    = 8,
    parameter int EVICT_ON_FULL = 0,
    localparam int PRIO_WIDTH   = $clog2(MAX_PRIORITY),
    localparam int CNT_WIDTH    = $clog2(NUM_ELEMENTS + 1)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  i__data_in_valid,
    input  logic [PRIO_WIDTH-1:0] i__data_in_priority,
    input  logic [DATA_WIDTH-1:0] i__data_in,
    output logic                  o__data_in_ready,
    output logic                  o__data_in_ready__next,
    output logic                  o__data_out_valid,
    output logic [PRIO_WIDTH-1:0] o__data_out_priority,
    output logic [DATA_WIDTH-1:0] o__data_out,
    input  logic                  i__data_out_ready,
    input  logic                  i__clear_all,
    output logic [CNT_WIDTH-1:0]  o__occupancy,
    output logic                  o__drop_valid,
    output logic [PRIO_WIDTH-1:0] o__drop_priority,
    output logic [DATA_WIDTH-1:0] o__drop_data
);

    typedef logic [PRIO_WIDTH-1:0] prio_t;
    typedef logic [DATA_WIDTH-1:0] data_t;

    localparam logic [CNT_WIDTH-1:0] FULL_CNT = CNT_WIDTH'(NUM_ELEMENTS);
    localparam bit EVICT = (EVICT_ON_FULL != 0);

    prio_t                prio_q [NUM_ELEMENTS];
    data_t                data_q [NUM_ELEMENTS];
    logic [CNT_WIDTH-1:0] cnt_q;
    logic                 drop_vld_q;
    prio_t                drop_prio_q;
    data_t                drop_dat_q;

    prio_t                post_prio [NUM_ELEMENTS];
    data_t                post_dat  [NUM_ELEMENTS];
    prio_t                nxt_prio  [NUM_ELEMENTS];
    data_t                nxt_dat   [NUM_ELEMENTS];
    logic [CNT_WIDTH-1:0] post_cnt;
    logic [CNT_WIDTH-1:0] ins_idx;
    logic [CNT_WIDTH-1:0] nxt_cnt;
    logic                 full;
    logic                 push;
    logic                 pop;
    logic                 full_push;
    logic                 evict_tail;
    logic                 reject_in;
    logic                 ins_en;
    logic                 drop_nxt;
    prio_t                drop_prio_nxt;
    data_t                drop_dat_nxt;

    assign full                 = (cnt_q == FULL_CNT);
    assign o__data_in_ready     = EVICT ? ~reset : (~full & ~reset);
    assign o__data_out_valid    = (cnt_q != '0);
    assign o__data_out_priority = prio_q[0];
    assign o__data_out          = data_q[0];
    assign o__occupancy         = cnt_q;
    assign o__drop_valid        = drop_vld_q;
    assign o__drop_priority     = drop_prio_q;
    assign o__drop_data         = drop_dat_q;

    assign push = i__data_in_valid & o__data_in_ready;
    assign pop  = i__data_out_ready & o__data_out_valid;

    always_comb begin
        // The pop is applied first; insertion works on the post-pop view.
        post_cnt = cnt_q - CNT_WIDTH'(pop);
        for (int i = 0; i < NUM_ELEMENTS; i++) begin
            post_prio[i] = prio_q[i];
            post_dat[i]  = data_q[i];
        end
        if (pop) begin
            for (int i = 0; i < NUM_ELEMENTS - 1; i++) begin
                post_prio[i] = prio_q[i + 1];
                post_dat[i]  = data_q[i + 1];
            end
            post_prio[NUM_ELEMENTS - 1] = '0;
            post_dat[NUM_ELEMENTS - 1]  = '0;
        end

        ins_idx = '0;
        for (int i = 0; i < NUM_ELEMENTS; i++) begin
            if ((CNT_WIDTH'(i) < post_cnt) && (post_prio[i] <= i__data_in_priority))
                ins_idx = ins_idx + CNT_WIDTH'(1);
        end

        full_push  = push & ~pop & full;
        evict_tail = full_push & (i__data_in_priority < prio_q[NUM_ELEMENTS - 1]);
        reject_in  = full_push & ~evict_tail;
        ins_en     = push & ~reject_in & ~i__clear_all;

        // When the tail is evicted the shift simply pushes it off the top slot.
        nxt_prio[0] = (ins_en && ins_idx == '0) ? i__data_in_priority : post_prio[0];
        nxt_dat[0]  = (ins_en && ins_idx == '0) ? i__data_in : post_dat[0];
        for (int i = 1; i < NUM_ELEMENTS; i++) begin
            if (ins_en && CNT_WIDTH'(i) == ins_idx) begin
                nxt_prio[i] = i__data_in_priority;
                nxt_dat[i]  = i__data_in;
            end else if (ins_en && CNT_WIDTH'(i) > ins_idx) begin
                nxt_prio[i] = post_prio[i - 1];
                nxt_dat[i]  = post_dat[i - 1];
            end else begin
                nxt_prio[i] = post_prio[i];
                nxt_dat[i]  = post_dat[i];
            end
        end

        if (i__clear_all)
            nxt_cnt = '0;
        else if (full_push)
            nxt_cnt = cnt_q;
        else
            nxt_cnt = post_cnt + CNT_WIDTH'(push);

        drop_nxt      = (evict_tail | reject_in) & ~i__clear_all;
        drop_prio_nxt = evict_tail ? prio_q[NUM_ELEMENTS - 1] : i__data_in_priority;
        drop_dat_nxt  = evict_tail ? data_q[NUM_ELEMENTS - 1] : i__data_in;

        if (reset)
            o__data_in_ready__next = 1'b0;
        else if (EVICT)
            o__data_in_ready__next = 1'b1;
        else
            o__data_in_ready__next = (nxt_cnt != FULL_CNT);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q       <= '0;
            drop_vld_q  <= 1'b0;
            drop_prio_q <= '0;
            drop_dat_q  <= '0;
            for (int i = 0; i < NUM_ELEMENTS; i++) begin
                prio_q[i] <= '0;
                data_q[i] <= '0;
            end
        end else begin
            cnt_q      <= nxt_cnt;
            drop_vld_q <= drop_nxt;
            if (drop_nxt) begin
                drop_prio_q <= drop_prio_nxt;
                drop_dat_q  <= drop_dat_nxt;
            end
            for (int i = 0; i < NUM_ELEMENTS; i++) begin
                prio_q[i] <= nxt_prio[i];
                data_q[i] <= nxt_dat[i];
            end
        end
    end

endmodule

// File: tb/tb_pifo_shift.sv
// Bench for pifo_shift: three instances (depth 4 blocking, depth 4 evicting, depth 16 blocking)
// share one stimulus stream; each is compared every cycle against a sorted-array reference.
module tb_pifo_shift;

    localparam int ND = 3;
    localparam int PW = 8;
    localparam int DW = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset;
    logic          in_vld;
    logic          out_rdy;
    logic          clr;
    logic [PW-1:0] in_prio;
    logic [DW-1:0] in_dat;

    logic [ND-1:0]         rdy_w;
    logic [ND-1:0]         rdy_nx_w;
    logic [ND-1:0]         vld_w;
    logic [ND-1:0]         drop_vld_w;
    logic [ND-1:0][PW-1:0] prio_w;
    logic [ND-1:0][PW-1:0] drop_prio_w;
    logic [ND-1:0][DW-1:0] dat_w;
    logic [ND-1:0][DW-1:0] drop_dat_w;
    logic [ND-1:0][7:0]    occ_w;

    for (genvar g = 0; g < ND; g++) begin : g_dut
        localparam int N  = (g == 2) ? 16 : 4;
        localparam int EV = (g == 1) ? 1 : 0;
        logic [$clog2(N+1)-1:0] occ;
        pifo_shift #(
            .NUM_ELEMENTS (N),
            .MAX_PRIORITY (256),
            .DATA_WIDTH   (DW),
            .EVICT_ON_FULL(EV)
        ) u_dut (
            .clk                   (clk),
            .reset                 (reset),
            .i__data_in_valid      (in_vld),
            .i__data_in_priority   (in_prio),
            .i__data_in            (in_dat),
            .o__data_in_ready      (rdy_w[g]),
            .o__data_in_ready__next(rdy_nx_w[g]),
            .o__data_out_valid     (vld_w[g]),
            .o__data_out_priority  (prio_w[g]),
            .o__data_out           (dat_w[g]),
            .i__data_out_ready     (out_rdy),
            .i__clear_all          (clr),
            .o__occupancy          (occ),
            .o__drop_valid         (drop_vld_w[g]),
            .o__drop_priority      (drop_prio_w[g]),
            .o__drop_data          (drop_dat_w[g])
        );
        assign occ_w[g] = 8'(occ);
    end

    // Reference state: plain sorted arrays per instance.
    int m_cnt    [ND];
    int m_prio   [ND][16];
    int m_dat    [ND][16];
    bit m_zero   [ND];
    bit m_drop_v [ND];
    int m_drop_p [ND];
    int m_drop_d [ND];

    int n_checks = 0;
    int n_fail   = 0;
    bit armed    = 1'b0;

    typedef struct {
        int v; int p; int d; int pop;
        int e_vld; int e_prio; int e_dat; int e_occ; int e_rdy; int e_rdy_nx;
    } vec_t;
    vec_t tbl [16];

    function automatic int depth_of(input int k);
        return (k == 2) ? 16 : 4;
    endfunction

    function automatic bit evict_of(input int k);
        return (k == 1);
    endfunction

    function automatic vec_t mk(input int v, input int p, input int d, input int pop, input int ev,
                                input int ep, input int ed, input int eo, input int er, input int en);
        vec_t r;
        r.v = v; r.p = p; r.d = d; r.pop = pop;
        r.e_vld = ev; r.e_prio = ep; r.e_dat = ed; r.e_occ = eo; r.e_rdy = er; r.e_rdy_nx = en;
        return r;
    endfunction

    task automatic chk(input string name, input int k, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s dut%0d: got %0d expected %0d at %0t", name, k, act, exp, $time);
        end
    endtask

    task automatic m_insert(input int k, input int p, input int d);
        int pos = 0;
        for (int i = 0; i < m_cnt[k]; i++)
            if (m_prio[k][i] <= p) pos++;
        for (int i = m_cnt[k]; i > pos; i--) begin
            m_prio[k][i] = m_prio[k][i-1];
            m_dat[k][i]  = m_dat[k][i-1];
        end
        m_prio[k][pos] = p;
        m_dat[k][pos]  = d;
        m_cnt[k]++;
    endtask

    task automatic model_step(input int k, input bit rst, input bit v, input int p, input int d,
                              input bit pop, input bit c);
        int n = depth_of(k);
        bit push;
        bit popf;
        m_drop_v[k] = 1'b0;
        if (rst) begin
            m_cnt[k] = 0; m_zero[k] = 1'b1; m_drop_p[k] = 0; m_drop_d[k] = 0;
            return;
        end
        push = v && (evict_of(k) || m_cnt[k] < n);
        popf = pop && m_cnt[k] > 0;
        if (c) begin
            m_cnt[k] = 0;
            return;
        end
        if (popf) begin
            for (int i = 0; i < m_cnt[k] - 1; i++) begin
                m_prio[k][i] = m_prio[k][i+1];
                m_dat[k][i]  = m_dat[k][i+1];
            end
            m_cnt[k]--;
        end
        if (push) begin
            m_zero[k] = 1'b0;
            if (m_cnt[k] == n) begin
                m_drop_v[k] = 1'b1;
                if (p < m_prio[k][n-1]) begin
                    m_drop_p[k] = m_prio[k][n-1];
                    m_drop_d[k] = m_dat[k][n-1];
                    m_cnt[k]--;
                    m_insert(k, p, d);
                end else begin
                    m_drop_p[k] = p;
                    m_drop_d[k] = d;
                end
            end else begin
                m_insert(k, p, d);
            end
        end
    endtask

    task automatic check_pre(input int k, input bit rst);
        int exp_rdy = (!rst && (evict_of(k) || m_cnt[k] < depth_of(k))) ? 1 : 0;
        chk("ready", k, int'(rdy_w[k]), exp_rdy);
        chk("out_valid", k, int'(vld_w[k]), (m_cnt[k] != 0) ? 1 : 0);
        chk("occupancy", k, int'(occ_w[k]), m_cnt[k]);
        if (m_cnt[k] != 0 || m_zero[k]) begin
            chk("head_prio", k, int'(prio_w[k]), (m_cnt[k] != 0) ? m_prio[k][0] : 0);
            chk("head_data", k, int'(dat_w[k]), (m_cnt[k] != 0) ? m_dat[k][0] : 0);
        end
        chk("drop_valid", k, int'(drop_vld_w[k]), int'(m_drop_v[k]));
        if (m_drop_v[k] || m_zero[k]) begin
            chk("drop_prio", k, int'(drop_prio_w[k]), m_drop_p[k]);
            chk("drop_data", k, int'(drop_dat_w[k]), m_drop_d[k]);
        end
    endtask

    // Drives one cycle's inputs after the falling edge and checks pre-edge outputs; returns before the rising edge.
    task automatic apply(input bit rst, input bit v, input int p, input int d, input bit pop, input bit c);
        int exp_nx;
        @(negedge clk);
        reset = rst; in_vld = v; in_prio = PW'(p); in_dat = DW'(d); out_rdy = pop; clr = c;
        #1;
        for (int k = 0; k < ND; k++) begin
            if (armed) check_pre(k, rst);
            model_step(k, rst, v, p, d, pop, c);
            exp_nx = (!rst && (evict_of(k) || m_cnt[k] != depth_of(k))) ? 1 : 0;
            if (armed) chk("ready_next", k, int'(rdy_nx_w[k]), exp_nx);
        end
        armed = 1'b1;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1; in_vld = 1'b0; in_prio = '0; in_dat = '0; out_rdy = 1'b0; clr = 1'b0;

        tbl[0]  = mk(1, 5, 'hA1, 0,  0, 0, 0,     0, 1, 1);
        tbl[1]  = mk(1, 2, 'hB2, 0,  1, 5, 'hA1,  1, 1, 1);
        tbl[2]  = mk(1, 9, 'hC3, 0,  1, 2, 'hB2,  2, 1, 1);
        tbl[3]  = mk(1, 2, 'hD4, 0,  1, 2, 'hB2,  3, 1, 0);
        tbl[4]  = mk(1, 1, 'hE5, 0,  1, 2, 'hB2,  4, 0, 0);
        tbl[5]  = mk(1, 1, 'hE5, 1,  1, 2, 'hB2,  4, 0, 1);
        tbl[6]  = mk(0, 0, 0,    1,  1, 2, 'hD4,  3, 1, 1);
        tbl[7]  = mk(0, 0, 0,    1,  1, 5, 'hA1,  2, 1, 1);
        tbl[8]  = mk(0, 0, 0,    1,  1, 9, 'hC3,  1, 1, 1);
        tbl[9]  = mk(0, 0, 0,    0,  0, 0, 0,     0, 1, 1);
        tbl[10] = mk(1, 1, 'h58, 0,  0, 0, 0,     0, 1, 1);
        tbl[11] = mk(1, 4, 'h59, 0,  1, 1, 'h58,  1, 1, 1);
        tbl[12] = mk(1, 3, 'h5A, 1,  1, 1, 'h58,  2, 1, 1);
        tbl[13] = mk(0, 0, 0,    1,  1, 3, 'h5A,  2, 1, 1);
        tbl[14] = mk(0, 0, 0,    1,  1, 4, 'h59,  1, 1, 1);
        tbl[15] = mk(0, 0, 0,    0,  0, 0, 0,     0, 1, 1);

        // Power-on reset, then reset values.
        repeat (2) begin
            apply(1'b1, 1'b1, 3, 3, 1'b0, 1'b0);
            tick;
        end
        for (int k = 0; k < ND; k++) begin
            chk("rst_occupancy", k, int'(occ_w[k]), 0);
            chk("rst_valid", k, int'(vld_w[k]), 0);
            chk("rst_head_data", k, int'(dat_w[k]), 0);
            chk("rst_drop_valid", k, int'(drop_vld_w[k]), 0);
        end

        // Ordered drain, full blocking, simultaneous push/pop (hand-derived for dut0).
        for (int i = 0; i < 16; i++) begin
            apply(1'b0, tbl[i].v != 0, tbl[i].p, tbl[i].d, tbl[i].pop != 0, 1'b0);
            chk("tbl_ready", 0, int'(rdy_w[0]), tbl[i].e_rdy);
            chk("tbl_ready_next", 0, int'(rdy_nx_w[0]), tbl[i].e_rdy_nx);
            chk("tbl_valid", 0, int'(vld_w[0]), tbl[i].e_vld);
            chk("tbl_occupancy", 0, int'(occ_w[0]), tbl[i].e_occ);
            if (tbl[i].e_vld != 0) begin
                chk("tbl_head_prio", 0, int'(prio_w[0]), tbl[i].e_prio);
                chk("tbl_head_data", 0, int'(dat_w[0]), tbl[i].e_dat);
            end
            tick;
        end
        repeat (6) begin
            apply(1'b0, 1'b0, 0, 0, 1'b1, 1'b0);
            tick;
        end

        // Evict on full: depth 4 holding {1,3,6,8}.
        apply(1'b0, 1'b1, 8, 'h18, 1'b0, 1'b0); tick;
        apply(1'b0, 1'b1, 1, 'h11, 1'b0, 1'b0); tick;
        apply(1'b0, 1'b1, 6, 'h16, 1'b0, 1'b0); tick;
        apply(1'b0, 1'b1, 3, 'h13, 1'b0, 1'b0); tick;
        apply(1'b0, 1'b1, 2, 'h12, 1'b0, 1'b0); tick;
        chk("evict_drop_valid", 1, int'(drop_vld_w[1]), 1);
        chk("evict_drop_prio", 1, int'(drop_prio_w[1]), 8);
        chk("evict_drop_data", 1, int'(drop_dat_w[1]), 'h18);
        chk("blocked_no_drop", 0, int'(drop_vld_w[0]), 0);
        apply(1'b0, 1'b1, 9, 'h19, 1'b0, 1'b0); tick;
        chk("reject_drop_valid", 1, int'(drop_vld_w[1]), 1);
        chk("reject_drop_prio", 1, int'(drop_prio_w[1]), 9);
        chk("reject_drop_data", 1, int'(drop_dat_w[1]), 'h19);
        apply(1'b0, 1'b0, 0, 0, 1'b0, 1'b0); tick;
        chk("drop_pulse_end", 1, int'(drop_vld_w[1]), 0);
        chk("evict_head_prio", 1, int'(prio_w[1]), 1);
        apply(1'b0, 1'b0, 0, 0, 1'b1, 1'b0); tick;
        chk("evict_head2", 1, int'(prio_w[1]), 2);
        chk("evict_head2_data", 1, int'(dat_w[1]), 'h12);
        apply(1'b0, 1'b0, 0, 0, 1'b1, 1'b0); tick;
        chk("evict_head3", 1, int'(prio_w[1]), 3);
        apply(1'b0, 1'b0, 0, 0, 1'b1, 1'b0); tick;
        chk("evict_head4", 1, int'(prio_w[1]), 6);
        apply(1'b0, 1'b0, 0, 0, 1'b1, 1'b0); tick;
        chk("evict_empty", 1, int'(vld_w[1]), 0);

        // Clear overrides push and pop.
        apply(1'b0, 1'b1, 7, 'h71, 1'b0, 1'b0); tick;
        apply(1'b0, 1'b1, 5, 'h72, 1'b0, 1'b0); tick;
        apply(1'b0, 1'b1, 7, 'h73, 1'b0, 1'b0); tick;
        apply(1'b0, 1'b1, 4, 'h74, 1'b1, 1'b1); tick;
        for (int k = 0; k < ND; k++) begin
            chk("clear_occupancy", k, int'(occ_w[k]), 0);
            chk("clear_valid", k, int'(vld_w[k]), 0);
            chk("clear_no_drop", k, int'(drop_vld_w[k]), 0);
        end

        // Reset mid-stream with push held.
        for (int i = 0; i < 5; i++) begin
            apply(1'b0, 1'b1, 10 - i, 'h80 + i, 1'b0, 1'b0);
            tick;
        end
        chk("pre_reset_occupancy", 2, int'(occ_w[2]), 5);
        repeat (2) begin
            apply(1'b1, 1'b1, 2, 'h99, 1'b1, 1'b0);
            chk("ready_in_reset", 2, int'(rdy_w[2]), 0);
            tick;
        end
        apply(1'b0, 1'b0, 0, 0, 1'b0, 1'b0);
        for (int k = 0; k < ND; k++) begin
            chk("post_reset_ready", k, int'(rdy_w[k]), 1);
            chk("post_reset_occupancy", k, int'(occ_w[k]), 0);
            chk("post_reset_head_prio", k, int'(prio_w[k]), 0);
        end
        tick;

        // Randomized traffic with varying push/pop balance.
        for (int ph = 0; ph < 3; ph++) begin
            int pv = (ph == 0) ? 50 : (ph == 1) ? 85 : 30;
            for (int i = 0; i < 700; i++) begin
                apply($urandom_range(0, 199) == 0,
                      $urandom_range(0, 99) < pv,
                      int'($urandom_range(0, 15)),
                      int'($urandom_range(0, 255)),
                      $urandom_range(0, 99) >= pv,
                      $urandom_range(0, 59) == 0);
                tick;
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
